dmem_dma: RTL and testbench

Word-copy DMA initiator that drives the single port of the data memory (`we`, `a`, `wd`, `rd`) and moves a block of words from one byte address to another. It sits beside the processor datapath on the data-memory port and is selected by an external mux while `busy` is high. It provides a start/busy/done handshake and validates the request before it issues any access.

---
 rtl/dmem_dma_pkg.sv | 17 +
 rtl/dmem_range_chk.sv | 29 ++
 rtl/dmem_dma.sv | 128 ++++++++++++
 tb/tb_dmem_dma.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dma_pkg.sv
// dmem_dma_pkg: shared types and constants for the data-memory word-copy DMA.
//   state_e     : copy engine FSM states
//   WORD_BYTES  : byte stride between consecutive 32-bit words
//   DMEM_DEPTH  : default number of words in the target data memory
package dmem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int DMEM_DEPTH = 64;

endpackage

// File: rtl/dmem_range_chk.sv
// dmem_range_chk: combinational request validator for one block base address.
//   base         in  byte address of the first word
//   len          in  number of words in the block
//   misaligned   out base is not word aligned
//   out_of_range out last word of the block falls past DEPTH words
// DEPTH is the memory size in words, supplied as a parameter.
module dmem_range_chk
  import dmem_dma_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LW    = 7
) (
  input  logic [31:0]   base,
  input  logic [LW-1:0] len,
  output logic          misaligned,
  output logic          out_of_range
);

  // 33-bit sum: a base near the top of the address space cannot wrap
  // back into range.
  logic [32:0] end_word;

  always_comb begin
    end_word     = {3'b000, base[31:2]} + {{(33-LW){1'b0}}, len};
    misaligned   = |base[1:0];
    out_of_range = end_word > 33'(DEPTH);
  end

endmodule

// File: rtl/dmem_dma.sv
// dmem_dma: word-copy DMA initiator on the single data-memory port.
//   clk, reset_n      clock, asynchronous active-low reset
//   start/src/dst/len copy request, sampled only while idle
//   busy              high while the copy is reading/writing
//   done, err         one-cycle completion pulse; err flags a rejected request
//   mem_we/a/wd/rd    data-memory port, mem_rd is combinational from mem_a
// Each word takes two cycles: READ latches mem_rd into a buffer, WRITE stores
// it. Memory outputs decode only from registered state, so start never
// reaches the memory port combinationally.
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LW    = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [31:0]   src,
  input  logic [31:0]   dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  state_e        state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic          err_q, err_d;

  logic src_mis, src_oor, dst_mis, dst_oor;
  logic reject;

  dmem_range_chk #(.DEPTH(DEPTH), .LW(LW)) u_src_chk (
    .base        (src),
    .len         (len),
    .misaligned  (src_mis),
    .out_of_range(src_oor)
  );

  dmem_range_chk #(.DEPTH(DEPTH), .LW(LW)) u_dst_chk (
    .base        (dst),
    .len         (len),
    .misaligned  (dst_mis),
    .out_of_range(dst_oor)
  );

  assign reject = src_mis | src_oor | dst_mis | dst_oor;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          cnt_d = len;
          err_d = reject;
          // Rejection wins over an empty copy; both finish without any access.
          if (reject || len == '0) state_d = DONE;
          else                     state_d = READ;
        end
      end
      READ: begin
        buf_d   = mem_rd;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + 32'(WORD_BYTES);
        dst_d   = dst_q + 32'(WORD_BYTES);
        cnt_d   = cnt_q - LW'(1);
        state_d = (cnt_q == LW'(1)) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (state_q)
      READ: mem_a = src_q;
      WRITE: begin
        mem_a  = dst_q;
        mem_wd = buf_q;
        mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == READ) || (state_q == WRITE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: scoreboard bench for dmem_dma with a 64-word behavioural RAM.
// Stimulus pushes expected writes and done pulses; a negedge monitor pops and
// compares them (data, address, cycle) whenever the DUT presents one.
module tb_dmem_dma;

  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src = '0;
  logic [31:0]   dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err, mem_we;
  logic [31:0]   mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_dma #(.DEPTH(64), .LW(LW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  // Behavioural RAM: DUT port plus a bench-side preload port.
  logic [31:0] ram [64];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;

  assign mem_rd = ram[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we)     ram[mem_a[7:2]] <= mem_wd;
    else if (tb_we) ram[tb_wa]      <= tb_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    int          at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   bw_lo = 1;
  int   bw_hi = 0;
  bit   mon_en = 1'b0;
  int   we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (mem_we) begin
        we_cnt++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got a=%0h wd=%0h want none (cyc %0d)", mem_a, mem_wd, cyc);
        end else begin
          e = q.pop_front();
          chk("wr_kind", {31'd0, e.is_done}, 32'd0);
          chk("wr_addr", mem_a, e.addr);
          chk("wr_data", mem_wd, e.data);
          chk("wr_cycle", cyc, e.at);
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 want none (cyc %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_kind", {31'd0, e.is_done}, 32'd1);
          chk("done_err", {31'd0, err}, {31'd0, e.err});
          chk("done_cycle", cyc, e.at);
          chk("done_mem_a", mem_a, 32'd0);
        end
      end
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= bw_lo && cyc <= bw_hi)});
    end
  end

  task automatic poke(input int i, input logic [31:0] v);
    tb_we = 1'b1; tb_wa = 6'(i); tb_wd = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue a request at a negedge; the next posedge (edge n) samples it.
  task automatic go(input logic [31:0] s, input logic [31:0] d, input int l, input bit e,
                    input logic [31:0] d0, input logic [31:0] d1,
                    input logic [31:0] d2, input logic [31:0] d3, output int n_o);
    logic [31:0] dv [4];
    exp_t x;
    int n;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    src = s; dst = d; len = LW'(l); start = 1'b1;
    n = cyc + 1;
    if (!e) begin
      for (int k = 0; k < l; k++) begin
        x.is_done = 1'b0; x.addr = d + 32'(4 * k); x.data = dv[k]; x.err = 1'b0;
        x.at = n + 1 + 2 * k;
        q.push_back(x);
      end
    end
    x.is_done = 1'b1; x.addr = '0; x.data = '0; x.err = e;
    x.at = n + (e ? 0 : 2 * l);
    q.push_back(x);
    if (!e && l > 0) begin bw_lo = n; bw_hi = n + 2 * l - 1; end
    else             begin bw_lo = 1; bw_hi = 0; end
    n_o = n;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, q.size(), 32'd0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},   32'd0);
    chk({tag, "_done"},   {31'd0, done},   32'd0);
    chk({tag, "_err"},    {31'd0, err},    32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_a"},  mem_a,           32'd0);
    chk({tag, "_mem_wd"}, mem_wd,          32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, 32'd0);
    mon_en = 1'b1;

    // Basic 4-word copy.
    poke(0, 32'd11); poke(1, 32'd22); poke(2, 32'd33); poke(3, 32'd44);
    we_cnt = 0;
    go(32'h0, 32'h40, 4, 1'b0, 32'd11, 32'd22, 32'd33, 32'd44, n);
    drain("t1_drain");
    chk("t1_we_count", we_cnt, 32'd4);
    chk("t1_ram16", ram[16], 32'd11);
    chk("t1_ram17", ram[17], 32'd22);
    chk("t1_ram18", ram[18], 32'd33);
    chk("t1_ram19", ram[19], 32'd44);

    // Empty copy, then two rejections; none may write.
    we_cnt = 0;
    go(32'h10, 32'h20, 0, 1'b0, 0, 0, 0, 0, n);
    drain("len0_drain");
    go(32'h2, 32'h40, 2, 1'b1, 0, 0, 0, 0, n);
    drain("mis_drain");
    repeat (3) @(negedge clk);
    chk("err_hold", {31'd0, err}, 32'd1);
    go(32'h0, 32'hF8, 3, 1'b1, 0, 0, 0, 0, n);
    drain("oor_drain");
    chk("reject_we_count", we_cnt, 32'd0);
    chk("reject_ram16", ram[16], 32'd11);
    chk("reject_ram62", ram[62], 32'd0);

    // Last two words of memory: exactly at the limit, accepted.
    go(32'h0, 32'hF8, 2, 1'b0, 32'd11, 32'd22, 0, 0, n);
    drain("edge_drain");
    chk("edge_err", {31'd0, err}, 32'd0);
    chk("edge_ram62", ram[62], 32'd11);
    chk("edge_ram63", ram[63], 32'd22);

    // Forward overlap: the second read sees the first write.
    poke(0, 32'hA); poke(1, 32'hB); poke(2, 32'hC);
    go(32'h0, 32'h4, 2, 1'b0, 32'hA, 32'hA, 0, 0, n);
    drain("ovl_drain");
    chk("ovl_ram1", ram[1], 32'hA);
    chk("ovl_ram2", ram[2], 32'hA);

    // Start while busy must be ignored.
    poke(0, 32'h100); poke(1, 32'h200); poke(2, 32'h300);
    go(32'h0, 32'h80, 3, 1'b0, 32'h100, 32'h200, 32'h300, 0, n);
    src = 32'h10; dst = 32'hC0; len = LW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("busy_drain");
    chk("busy_ram32", ram[32], 32'h100);
    chk("busy_ram34", ram[34], 32'h300);
    chk("busy_ram48", ram[48], 32'd0);

    // Reset after word 1 has been written.
    poke(0, 32'h1111); poke(1, 32'h2222); poke(2, 32'h3333); poke(3, 32'h4444);
    go(32'h0, 32'h40, 4, 1'b0, 32'h1111, 32'h2222, 32'h3333, 32'h4444, n);
    repeat (4) @(negedge clk);
    #2;
    chk("rst_pending", q.size(), 32'd3);
    reset_n = 1'b0;
    q.delete();
    bw_lo = 1; bw_hi = 0;
    #1;
    chk_quiet("midrst");
    chk("midrst_ram17", ram[17], 32'h2222);
    chk("midrst_ram18", ram[18], 32'd33);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    go(32'h0, 32'h40, 4, 1'b0, 32'h1111, 32'h2222, 32'h3333, 32'h4444, n);
    drain("post_rst_drain");
    chk("post_rst_ram18", ram[18], 32'h3333);
    chk("post_rst_ram19", ram[19], 32'h4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
